// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned DataW = 4;
  localparam int unsigned OpW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam logic [OpW-1:0] OpAnd  = 3'b000;
  localparam logic [OpW-1:0] OpOr   = 3'b001;
  localparam logic [OpW-1:0] OpAdd  = 3'b010;
  localparam logic [OpW-1:0] OpEq   = 3'b011;
  localparam logic [OpW-1:0] OpAndn = 3'b100;
  localparam logic [OpW-1:0] OpOrn  = 3'b101;
  localparam logic [OpW-1:0] OpSub  = 3'b110;
  localparam logic [OpW-1:0] OpGt   = 3'b111;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the requesters, the result consumer and alu_sched.
interface alu_sched_if
  import alu_sched_pkg::*;
();

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OpW-1:0]   req0_op;
  logic [OpW-1:0]   req1_op;
  logic [DataW-1:0] req0_a;
  logic [DataW-1:0] req0_b;
  logic [DataW-1:0] req1_a;
  logic [DataW-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [DataW-1:0] res_y;

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, res_ready,
    input  req_ready, res_valid, res_id, res_y
  );

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, res_ready,
    output req_ready, res_valid, res_id, res_y
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr_i names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o,
  output logic       win_id_o
);

  always_comb begin
    win_id_o = 1'b0;
    case (valid_i)
      2'b10:   win_id_o = 1'b1;
      2'b11:   win_id_o = ptr_i;
      default: win_id_o = 1'b0;
    endcase
    grant_o = 2'b00;
    if (enable_i && (|valid_i)) begin
      grant_o = win_id_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/src.sv
// Shared 4-bit ALU, 3-bit opcode; purely combinational, no carry/overflow output.
module src
  import alu_sched_pkg::*;
(
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  input  logic [OpW-1:0]   f_i,
  output logic [DataW-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (f_i)
      OpAnd:   y_o = a_i & b_i;
      OpOr:    y_o = a_i | b_i;
      OpAdd:   y_o = a_i + b_i;
      OpEq:    y_o = {{(DataW-1){1'b0}}, a_i == b_i};
      OpAndn:  y_o = a_i & ~b_i;
      OpOrn:   y_o = a_i | ~b_i;
      OpSub:   y_o = a_i - b_i;
      OpGt:    y_o = {{(DataW-1){1'b0}}, a_i > b_i};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler serialising two requesters onto one ALU (IDLE -> EXEC -> RESP).
// Define ALU_SCHED_STATS_EN to build the saturating per-requester grant counters.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_sched_if.slave       bus,
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [DataW-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [1:0]       grant;
  logic             win_id;
  logic             arb_en;
  logic [DataW-1:0] alu_y;

  // Gating with rst keeps req_ready at its reset value while reset is held.
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arb2 u_arb (
    .valid_i  (bus.req_valid),
    .enable_i (arb_en),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .win_id_o (win_id)
  );

  src u_alu (
    .a_i (a_q),
    .b_i (b_q),
    .f_i (op_q),
    .y_o (alu_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          id_d    = win_id;
          op_d    = win_id ? bus.req1_op : bus.req0_op;
          a_d     = win_id ? bus.req1_a  : bus.req0_a;
          b_d     = win_id ? bus.req1_b  : bus.req0_b;
          ptr_d   = ~win_id;
          state_d = StExec;
        end
      end
      StExec: begin
        y_d     = alu_y;
        state_d = StResp;
      end
      StResp: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = (state_q == StResp);
  assign bus.res_id    = id_q;
  assign bus.res_y     = y_q;
  assign busy          = (state_q != StIdle);

`ifdef ALU_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant[0] && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (grant[1] && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed scoreboard bench for alu_sched; counters checked against a model when
// ALU_SCHED_STATS_EN is defined, against zero otherwise.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int unsigned CntW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [CntW-1:0] gnt_cnt0, gnt_cnt1;

  alu_sched_if bus ();

  alu_sched #(.CNT_W(CntW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [3:0] y;
  } exp_t;

  typedef enum int {MIdle, MExec, MResp} mstate_e;

  exp_t    sb[$];
  logic    gnt_log[$];
  int      checks = 0;
  int      errors = 0;
  mstate_e m_state;
  logic    m_ptr;
  int      m_cnt0, m_cnt1;

  function automatic logic [3:0] ref_alu(input logic [2:0] f, input logic [3:0] a,
                                         input logic [3:0] b);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 4'((a + b) % 16);
      3'd3: return (a == b) ? 4'd1 : 4'd0;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return 4'((16 + a - b) % 16);
      default: return (a > b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_ptr   = 1'b0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    sb.delete();
  endtask

  task automatic chk_counters(input string tag);
`ifdef ALU_SCHED_STATS_EN
    chk({tag, "_cnt0"}, 32'(gnt_cnt0), 32'(m_cnt0));
    chk({tag, "_cnt1"}, 32'(gnt_cnt1), 32'(m_cnt1));
`else
    chk({tag, "_cnt0"}, 32'(gnt_cnt0), 32'd0);
    chk({tag, "_cnt1"}, 32'(gnt_cnt1), 32'd0);
`endif
  endtask

  // One clock: check at the falling edge, advance the model, return 1 ns after the rise.
  task automatic step();
    logic [1:0] g;
    logic       id;
    @(negedge clk);
    g = 2'b00;
    if (m_state == MIdle) begin
      if (bus.req_valid == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
      else                        g = bus.req_valid;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(g));
    chk("res_valid", 32'(bus.res_valid), 32'(m_state == MResp));
    chk("busy", 32'(busy), 32'(m_state != MIdle));
    chk_counters("step");
    if (m_state == MResp) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        chk("res_id", 32'(bus.res_id), 32'(sb[0].id));
        chk("res_y", 32'(bus.res_y), 32'(sb[0].y));
        if (bus.res_ready) void'(sb.pop_front());
      end
    end
    case (m_state)
      MIdle: begin
        if (g != 2'b00) begin
          id = g[1];
          sb.push_back({id, id ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b)
                               : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b)});
          gnt_log.push_back(id);
          m_ptr = ~id;
          if (!id && m_cnt0 < (1 << CntW) - 1) m_cnt0++;
          if (id && m_cnt1 < (1 << CntW) - 1) m_cnt1++;
          m_state = MExec;
        end
      end
      MExec:   m_state = MResp;
      default: if (bus.res_ready) m_state = MIdle;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req0_op   = 3'd0;
    bus.req1_op   = 3'd0;
    bus.req0_a    = 4'd0;
    bus.req0_b    = 4'd0;
    bus.req1_a    = 4'd0;
    bus.req1_b    = 4'd0;
    bus.res_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_res_y", 32'(bus.res_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_counters("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1.
    bus.req_valid = 2'b11;
    bus.req0_op = 3'b010; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
    bus.req1_op = 3'b001; bus.req1_a = 4'd4; bus.req1_b = 4'd8;
    for (int i = 0; i < 12; i++) step();
    bus.req_valid = 2'b00;
    chk("rr_n", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(gnt_log[i]), 32'(i % 2));
`ifdef ALU_SCHED_STATS_EN
    chk("rr_cnt0", 32'(gnt_cnt0), 32'd2);
    chk("rr_cnt1", 32'(gnt_cnt1), 32'd2);
`endif

    // Single add; payload scrambled after acceptance.
    do_reset();
    bus.req_valid = 2'b01;
    bus.req0_op = 3'b010; bus.req0_a = 4'd7; bus.req0_b = 4'd5;
    step();
    bus.req_valid = 2'b00;
    bus.req0_op = 3'b000; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    step();
    chk("add_valid", 32'(bus.res_valid), 32'd1);
    chk("add_y", 32'(bus.res_y), 32'hC);
    chk("add_id", 32'(bus.res_id), 32'd0);
    step();

    // Subtract wrap from requester 1.
    bus.req_valid = 2'b10;
    bus.req1_op = 3'b110; bus.req1_a = 4'd3; bus.req1_b = 4'd5;
    step();
    bus.req_valid = 2'b00;
    step();
    chk("sub_y", 32'(bus.res_y), 32'hE);
    chk("sub_id", 32'(bus.res_id), 32'd1);
    step();

    // Unsigned greater-than.
    bus.req_valid = 2'b01;
    bus.req0_op = 3'b111; bus.req0_a = 4'd9; bus.req0_b = 4'd4;
    step();
    bus.req_valid = 2'b00;
    step();
    chk("gt_y", 32'(bus.res_y), 32'h1);
    step();

    // Backpressure: 5 stalled cycles in RESP with both requesters waiting.
    gnt_log.delete();
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b11;
    bus.req0_op = 3'b100; bus.req0_a = 4'hF; bus.req0_b = 4'h5;
    bus.req1_op = 3'b101; bus.req1_a = 4'h2; bus.req1_b = 4'hC;
    step();
    step();
    for (int i = 0; i < 5; i++) step();
    chk("bp_grants", 32'(gnt_log.size()), 32'd1);
    bus.res_ready = 1'b1;
    step();
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    chk("bp_grants2", 32'(gnt_log.size()), 32'd2);

    // Reset during EXEC discards the operation and restores the pointer.
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_res_y", 32'(bus.res_y), 32'd0);
    model_reset();
    chk_counters("mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    bus.req_valid = 2'b00;
    chk("mid_tie_winner", 32'(gnt_log[gnt_log.size()-1]), 32'd0);
    step();
    step();

    // Saturation: five grants to requester 0.
    do_reset();
    bus.req_valid = 2'b01;
    for (int i = 0; i < 15; i++) step();
    bus.req_valid = 2'b00;
`ifdef ALU_SCHED_STATS_EN
    chk("sat_cnt0", 32'(gnt_cnt0), 32'd3);
`else
    chk("sat_cnt0", 32'(gnt_cnt0), 32'd0);
`endif
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
